// File: rtl/regfile16_wr_if.sv
// regfile16_wr_if: write/read bus of the 16-entry register file.
//   master: drives WrEn (one-hot from the 4:16 decoder), WriteData and
//           the two read addresses; observes read data and error status.
//   slave : the register file itself.
interface regfile16_wr_if #(
  parameter int WIDTH = 64,
  parameter int ERRW  = 8
);
  logic [15:0]      WrEn;
  logic [WIDTH-1:0] WriteData;
  logic [3:0]       ReadReg1;
  logic [3:0]       ReadReg2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             WrErr;
  logic [ERRW-1:0]  ErrCount;

  modport master (
    output WrEn, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WrErr, ErrCount
  );

  modport slave (
    input  WrEn, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WrErr, ErrCount
  );
endinterface

// File: rtl/regfile16_wr.sv
// regfile16_wr: 16 x WIDTH register file, one write port, two async reads.
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset (clears regs, WrErr, ErrCount)
//   rf    : regfile16_wr_if.slave
//           WrEn/WriteData      - one-hot write enable + data
//           ReadReg1/2 -> ReadData1/2 - combinational reads
//           WrErr               - registered pulse after a multi-hot WrEn
//           ErrCount            - saturating count of multi-hot writes
// Register ZERO_IDX reads 0 and ignores writes. Multi-hot enables write
// nothing.
// Optional macro REGFILE16_WR_BYPASS_EN: forward WriteData to a read port
// addressing the register being written in the same cycle.

// One register entry; the zero register collapses to a constant.
module regfile16_wr_entry #(
  parameter int WIDTH   = 64,
  parameter bit IS_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (IS_ZERO) begin : g_zero
      assign q = '0;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
      end
    end
  endgenerate
endmodule

module regfile16_wr #(
  parameter int WIDTH    = 64,
  parameter int ZERO_IDX = 15,
  parameter int ERRW     = 8
) (
  input  logic           clk,
  input  logic           reset,
  regfile16_wr_if.slave  rf
);
  localparam int NREG = 16;
  localparam logic [NREG-1:0] ZMASK = NREG'(1) << ZERO_IDX;

  logic [NREG-1:0][WIDTH-1:0] q;
  logic            multi;
  logic [NREG-1:0] wsel;
  logic            wrerr_q;
  logic [ERRW-1:0] errcnt_q;

  // x & (x-1) clears the lowest set bit; anything left means >= 2 bits set.
  assign multi = |(rf.WrEn & (rf.WrEn - NREG'(1)));

  // Effective write select: empty on multi-hot or reset, zero reg masked.
  assign wsel = (multi || reset) ? '0 : (rf.WrEn & ~ZMASK);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_ent
      regfile16_wr_entry #(
        .WIDTH   (WIDTH),
        .IS_ZERO (gi == ZERO_IDX)
      ) u_ent (
        .clk   (clk),
        .reset (reset),
        .we    (wsel[gi]),
        .d     (rf.WriteData),
        .q     (q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wrerr_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      wrerr_q <= multi;
      if (multi && (errcnt_q != {ERRW{1'b1}}))
        errcnt_q <= errcnt_q + ERRW'(1);
    end
  end

  assign rf.WrErr    = wrerr_q;
  assign rf.ErrCount = errcnt_q;

`ifdef REGFILE16_WR_BYPASS_EN
  // wsel already excludes the zero reg, multi-hot and reset cycles.
  assign rf.ReadData1 = wsel[rf.ReadReg1] ? rf.WriteData : q[rf.ReadReg1];
  assign rf.ReadData2 = wsel[rf.ReadReg2] ? rf.WriteData : q[rf.ReadReg2];
`else
  assign rf.ReadData1 = q[rf.ReadReg1];
  assign rf.ReadData2 = q[rf.ReadReg2];
`endif
endmodule

// File: tb/tb_regfile16_wr.sv
module tb_regfile16_wr;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile16_wr_if #(.WIDTH(64), .ERRW(8)) rf ();

  regfile16_wr #(.WIDTH(64), .ZERO_IDX(15), .ERRW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf.slave)
  );

  typedef struct {
    logic        rst;
    logic [15:0] wren;
    logic [63:0] wdata;
    logic [3:0]  rr1;
    logic [3:0]  rr2;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt [12];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive, clock once, then release the write so post-edge reads are plain.
  task automatic apply(input logic rst, input logic [15:0] wren, input logic [63:0] wd,
                       input logic [3:0] r1, input logic [3:0] r2);
    @(negedge clk);
    reset = rst; rf.WrEn = wren; rf.WriteData = wd;
    rf.ReadReg1 = r1; rf.ReadReg2 = r2;
    @(posedge clk); #1;
    reset = 1'b0; rf.WrEn = '0;
    #1;
  endtask

  initial begin
    reset = 1'b0; rf.WrEn = '0; rf.WriteData = '0; rf.ReadReg1 = '0; rf.ReadReg2 = '0;

    //         rst wren      wdata                   r1 r2 rd1                     rd2                     err cnt
    vt[0]  = '{1, 16'h0000, 64'h0,                  3, 7, 64'h0,                  64'h0,                  0, 0};
    vt[1]  = '{0, 16'h0008, 64'hDEAD_BEEF_0000_0001, 3, 0, 64'hDEAD_BEEF_0000_0001, 64'h0,                  0, 0};
    vt[2]  = '{0, 16'h0001, 64'h5,                  3, 0, 64'hDEAD_BEEF_0000_0001, 64'h5,                  0, 0};
    vt[3]  = '{0, 16'h0000, 64'h9,                  1, 2, 64'h0,                  64'h0,                  0, 0};
    vt[4]  = '{0, 16'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 15, 15, 64'h0,                 64'h0,                  0, 0};
    vt[5]  = '{0, 16'h0018, 64'h1234,               3, 4, 64'hDEAD_BEEF_0000_0001, 64'h0,                  1, 1};
    vt[6]  = '{0, 16'h0000, 64'h0,                  3, 4, 64'hDEAD_BEEF_0000_0001, 64'h0,                  0, 1};
    vt[7]  = '{0, 16'h0020, 64'hA,                  5, 5, 64'hA,                  64'hA,                  0, 1};
    vt[8]  = '{0, 16'h0000, 64'h0,                  0, 3, 64'h5,                  64'hDEAD_BEEF_0000_0001, 0, 1};
    vt[9]  = '{0, 16'h0003, 64'h99,                 0, 1, 64'h5,                  64'h0,                  1, 2};
    vt[10] = '{0, 16'hFFFF, 64'h77,                 5, 14, 64'hA,                 64'h0,                  1, 3};
    vt[11] = '{0, 16'h0000, 64'h0,                  5, 15, 64'hA,                 64'h0,                  0, 3};

    for (int i = 0; i < 12; i++) begin
      apply(vt[i].rst, vt[i].wren, vt[i].wdata, vt[i].rr1, vt[i].rr2);
      chk($sformatf("v%0d rd1", i), rf.ReadData1, vt[i].rd1);
      chk($sformatf("v%0d rd2", i), rf.ReadData2, vt[i].rd2);
      chk($sformatf("v%0d wrerr", i), 64'(rf.WrErr), 64'(vt[i].err));
      chk($sformatf("v%0d errcnt", i), 64'(rf.ErrCount), 64'(vt[i].cnt));
    end

    // Same-cycle read of the register being written (reg5 holds A).
    @(negedge clk);
    rf.WrEn = 16'h0020; rf.WriteData = 64'hB; rf.ReadReg1 = 4'd5; rf.ReadReg2 = 4'd0;
    #1;
`ifdef REGFILE16_WR_BYPASS_EN
    chk("bypass pre-edge", rf.ReadData1, 64'hB);
`else
    chk("nobypass pre-edge", rf.ReadData1, 64'hA);
`endif
    chk("other port pre-edge", rf.ReadData2, 64'h5);
    @(posedge clk); #1;
    rf.WrEn = '0;
    #1;
    chk("rw post-edge", rf.ReadData1, 64'hB);

    // Zero-register write must not be forwarded either.
    @(negedge clk);
    rf.WrEn = 16'h8000; rf.WriteData = 64'h1; rf.ReadReg1 = 4'd15;
    #1;
    chk("zero no fwd", rf.ReadData1, 64'h0);
    @(posedge clk); #1;
    rf.WrEn = '0;

    // Back-to-back multi-hot: WrErr held high, ErrCount saturates at 255.
    @(negedge clk);
    rf.WrEn = 16'h0018; rf.WriteData = 64'h1234; rf.ReadReg1 = 4'd3; rf.ReadReg2 = 4'd4;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (c % 50 == 49) chk($sformatf("sat wrerr c%0d", c), 64'(rf.WrErr), 64'h1);
    end
    chk("sat errcnt", 64'(rf.ErrCount), 64'd255);
    chk("sat reg3", rf.ReadData1, 64'hDEAD_BEEF_0000_0001);
    chk("sat reg4", rf.ReadData2, 64'h0);
    rf.WrEn = '0;
    @(posedge clk); #1;
    chk("sat wrerr drop", 64'(rf.WrErr), 64'h0);
    chk("sat errcnt hold", 64'(rf.ErrCount), 64'd255);

    // Reset during a write: write lost, everything cleared.
    apply(1'b1, 16'h0004, 64'h77, 4'd2, 4'd5);
    chk("rst-wr reg2", rf.ReadData1, 64'h0);
    chk("rst-wr reg5", rf.ReadData2, 64'h0);
    chk("rst-wr errcnt", 64'(rf.ErrCount), 64'h0);
    chk("rst-wr wrerr", 64'(rf.WrErr), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
